// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receive-side bundle: raw keyboard pins in, decoded scan-code stream out.
// master = keyboard/consumer side, slave = the receiver.
interface ps2_scancode_rx_if;
    logic       ps2_clock;
    logic       ps2_data;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       rx_error;
    logic       rx_busy;

    modport master (
        output ps2_clock,
        output ps2_data,
        input  ps2_key_pressed,
        input  ps2_key_data,
        input  rx_error,
        input  rx_busy
    );

    modport slave (
        input  ps2_clock,
        input  ps2_data,
        output ps2_key_pressed,
        output ps2_key_data,
        output rx_error,
        output rx_busy
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise and deglitch the pins, deserialise
// 11-bit frames, check start/odd-parity/stop, and abort stalled frames on timeout.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a start bit (data low on falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, delivering byte or error
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input logic             clk,
    input logic             clrn,
    ps2_scancode_rx_if.slave bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t       state, state_n;
    logic [1:0]   clk_sync, data_sync;
    logic [FW-1:0] flt_cnt;
    logic         clk_f, clk_f_prev;
    logic         fe, rx_bit, timeout;
    logic [CNT_W-1:0] to_cnt;
    logic [2:0]   bit_cnt, bit_cnt_n;
    logic [7:0]   shift, shift_n;
    logic         parity_bit, parity_n;
    logic [7:0]   key_data, key_data_n;
    logic         pressed, pressed_n;
    logic         error, error_n;

    // Two-flop synchronisers; pins idle high so reset to 1 avoids a false edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clock};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    // Filtered clock follows the synchronised pin only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            flt_cnt    <= '0;
            clk_f      <= 1'b1;
            clk_f_prev <= 1'b1;
        end else begin
            clk_f_prev <= clk_f;
            if (clk_sync[1] != clk_f) begin
                if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_f   <= clk_sync[1];
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fe      = clk_f_prev & ~clk_f;
    assign rx_bit  = data_sync[1];
    assign timeout = (state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            to_cnt <= '0;
        end else if (fe || state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            key_data   <= '0;
            pressed    <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            parity_bit <= parity_n;
            key_data   <= key_data_n;
            pressed    <= pressed_n;
            error      <= error_n;
        end
    end

    // Timeout takes priority over a coincident falling edge.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        parity_n   = parity_bit;
        key_data_n = key_data;
        pressed_n  = 1'b0;
        error_n    = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            error_n = 1'b1;
        end else if (fe) begin
            case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n   = {rx_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    parity_n = rx_bit;
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (rx_bit && (^{shift, parity_bit})) begin
                        key_data_n = shift;
                        pressed_n  = 1'b1;
                    end else begin
                        error_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.ps2_key_pressed = pressed;
    assign bus.ps2_key_data    = key_data;
    assign bus.rx_error        = error;
    assign bus.rx_busy         = (state != IDLE);

endmodule
